// File: rtl/rtc_timer_bank_if.sv
// ---------------------------------------------------------------------------
// rtc_timer_bank_if
//
// Purpose:
//   Register-port bundle for the machine timer bank. It carries the simple
//   req/we/be peripheral bus of the SoC. Signal suffixes are named from the
//   timer's (slave's) point of view.
//
// Signals:
//   req_i     request, one cycle per access
//   we_i      1 = write, 0 = read
//   addr_i    byte address, bits [2:0] ignored by the slave
//   be_i      byte enables for writes
//   wdata_i   write data
//   gnt_o     grant, equals req_i
//   rvalid_o  response valid one cycle after an accepted request
//   rdata_o   read data, valid with rvalid_o, otherwise 0
//
// Modports:
//   master  drives the request side (testbench / interconnect)
//   slave   drives the response side (rtc_timer_bank)
// ---------------------------------------------------------------------------
interface rtc_timer_bank_if #(
  parameter int unsigned ADDR_WIDTH = 16
) ();

  logic                  req_i;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [7:0]            be_i;
  logic [63:0]           wdata_i;
  logic                  gnt_o;
  logic                  rvalid_o;
  logic [63:0]           rdata_o;

  modport master (
    output req_i, we_i, addr_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, addr_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );

endinterface

// File: rtl/rtc_timer_bank.sv
// ---------------------------------------------------------------------------
// rtc_timer_bank
//
// Purpose:
//   Multi-hart machine timer. One shared 64-bit mtime counter and NR_CORES
//   mtimecmp registers. mtime advances on debounced rising edges of an
//   asynchronous RTC input, divided by a programmable prescaler. Each hart
//   gets a level interrupt while mtime >= its mtimecmp.
//
// Register map (byte offsets, bits [2:0] of the address ignored):
//   0x0000          CTRL: bit0 EN, bits [8+PRESCALE_WIDTH-1:8] DIV
//   0x0008          MTIME
//   0x1000 + 8*i    MTIMECMP[i], i < NR_CORES
//   Anything else reads 0 and ignores writes; rvalid_o still pulses.
//
// Ports:
//   clk_i     system clock
//   rst_ni    asynchronous active-low reset
//   bus       register port (rtc_timer_bank_if.slave)
//   rtc_i     asynchronous real-time clock input
//   time_o    current mtime
//   irq_o     per-hart timer interrupt
//
// Build option:
//   RTC_TIMER_IRQ_REG_EN  when defined, irq_o is registered (one extra cycle
//                         of latency after the compare result changes).
// ---------------------------------------------------------------------------
module rtc_timer_bank #(
  parameter int unsigned NR_CORES       = 1,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned STABLE_CYCLES  = 5,
  parameter int unsigned PRESCALE_WIDTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  rtc_timer_bank_if.slave     bus,
  input  logic                rtc_i,
  output logic [63:0]         time_o,
  output logic [NR_CORES-1:0] irq_o
);

  localparam int unsigned WORD_W   = ADDR_WIDTH - 3;
  localparam int unsigned CNT_W    = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((STABLE_CYCLES >= 2) ? STABLE_CYCLES - 2 : 0);
  localparam logic [31:0] CMP_BASE = 32'h0000_0200;

  typedef enum logic [1:0] {
    WAIT_HIGH,
    COUNT,
    TICK,
    WAIT_LOW
  } rtc_state_e;

  logic                      rtc_meta_q;
  logic                      rtc_s_q;
  rtc_state_e                state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      tick;

  logic                      en_q, en_d;
  logic [PRESCALE_WIDTH-1:0] div_q, div_d;
  logic [PRESCALE_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [63:0]               mtime_q, mtime_d;
  logic [63:0]               mtimecmp_q [NR_CORES];
  logic [63:0]               mtimecmp_d [NR_CORES];

  logic                      rvalid_q;
  logic [63:0]               rdata_q;

  logic [WORD_W-1:0]         word_idx;
  logic [2:0]                addr_unused;
  logic [31:0]               cmp_off;
  logic                      sel_ctrl, sel_mtime, sel_cmp;
  logic                      wr;
  logic [63:0]               wmask;
  logic [63:0]               ctrl_rd;
  logic [63:0]               rd_val;
  logic [NR_CORES-1:0]       irq_cmp;

  // Two-flop synchroniser followed by the debounce FSM. The FSM enters
  // COUNT on the first high sample and counts further high samples; the
  // tick fires once STABLE_CYCLES consecutive high samples have been seen,
  // then it waits for the line to drop so each high phase ticks only once.
  // It runs regardless of EN so enabling the timer mid-phase is harmless.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rtc_meta_q <= 1'b0;
      rtc_s_q    <= 1'b0;
      state_q    <= WAIT_HIGH;
      cnt_q      <= '0;
    end else begin
      rtc_meta_q <= rtc_i;
      rtc_s_q    <= rtc_meta_q;
      unique case (state_q)
        WAIT_HIGH: begin
          if (rtc_s_q) begin
            cnt_q   <= '0;
            state_q <= (STABLE_CYCLES <= 1) ? TICK : COUNT;
          end
        end
        COUNT: begin
          if (!rtc_s_q) begin
            state_q <= WAIT_HIGH;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= TICK;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        TICK: begin
          state_q <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (!rtc_s_q) begin
            state_q <= WAIT_HIGH;
          end
        end
        default: begin
          state_q <= WAIT_HIGH;
        end
      endcase
    end
  end

  assign tick = (state_q == TICK);

  // Address decode works on 64-bit word indices. MTIMECMP slots are found
  // by offsetting from word 0x200 and bounding by the number of harts.
  assign word_idx    = bus.addr_i[ADDR_WIDTH-1:3];
  assign addr_unused = bus.addr_i[2:0];
  assign cmp_off     = 32'(word_idx) - CMP_BASE;
  assign sel_ctrl    = (word_idx == '0);
  assign sel_mtime   = (word_idx == WORD_W'(1));
  assign sel_cmp     = (32'(word_idx) >= CMP_BASE) && (cmp_off < NR_CORES);
  assign wr          = bus.req_i && bus.we_i;

  // Byte enables expanded to a bit mask for the 64-bit registers.
  always_comb begin
    wmask = '0;
    for (int b = 0; b < 8; b++) begin
      wmask[b*8 +: 8] = {8{bus.be_i[b]}};
    end
  end

  // CTRL as seen on the bus; unimplemented bits read as zero.
  always_comb begin
    ctrl_rd                       = '0;
    ctrl_rd[0]                    = en_q;
    ctrl_rd[8 +: PRESCALE_WIDTH]  = div_q;
  end

  // Read mux sees only the current register state, so a same-cycle write
  // or increment never leaks into the returned data.
  always_comb begin
    rd_val = '0;
    if (sel_ctrl) begin
      rd_val = ctrl_rd;
    end else if (sel_mtime) begin
      rd_val = mtime_q;
    end else if (sel_cmp) begin
      for (int i = 0; i < NR_CORES; i++) begin
        if (cmp_off == i) begin
          rd_val = mtimecmp_q[i];
        end
      end
    end
  end

  // Next-state for the timer registers. The prescaler step is evaluated
  // first so that a bus write later in this block overrides it: a CTRL
  // write restarts the prescaler and an MTIME write discards a coincident
  // increment.
  always_comb begin
    en_d       = en_q;
    div_d      = div_q;
    pcnt_d     = pcnt_q;
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;

    if (tick && en_q) begin
      if (pcnt_q == div_q) begin
        pcnt_d  = '0;
        mtime_d = mtime_q + 64'd1;
      end else begin
        pcnt_d  = pcnt_q + PRESCALE_WIDTH'(1);
      end
    end

    if (wr && sel_ctrl) begin
      if (bus.be_i[0]) begin
        en_d = bus.wdata_i[0];
      end
      for (int j = 0; j < PRESCALE_WIDTH; j++) begin
        if (bus.be_i[(8 + j) / 8]) begin
          div_d[j] = bus.wdata_i[8 + j];
        end
      end
      pcnt_d = '0;
    end

    if (wr && sel_mtime) begin
      mtime_d = (mtime_q & ~wmask) | (bus.wdata_i & wmask);
    end

    for (int i = 0; i < NR_CORES; i++) begin
      if (wr && sel_cmp && (cmp_off == i)) begin
        mtimecmp_d[i] = (mtimecmp_q[i] & ~wmask) | (bus.wdata_i & wmask);
      end
    end
  end

  // Register state and the bus response. Every request, read or write,
  // gets a response one cycle later; rdata is zero unless it is a read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q     <= 1'b0;
      div_q    <= '0;
      pcnt_q   <= '0;
      mtime_q  <= '0;
      for (int i = 0; i < NR_CORES; i++) begin
        mtimecmp_q[i] <= '1;
      end
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      en_q       <= en_d;
      div_q      <= div_d;
      pcnt_q     <= pcnt_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      rvalid_q   <= bus.req_i;
      rdata_q    <= (bus.req_i && !bus.we_i) ? rd_val : '0;
    end
  end

  assign bus.gnt_o    = bus.req_i;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;
  assign time_o       = mtime_q;

  // Unsigned compare per hart, straight from the registers.
  always_comb begin
    irq_cmp = '0;
    for (int i = 0; i < NR_CORES; i++) begin
      irq_cmp[i] = (mtime_q >= mtimecmp_q[i]);
    end
  end

`ifdef RTC_TIMER_IRQ_REG_EN
  logic [NR_CORES-1:0] irq_q;

  // Registered interrupt lines for timing closure towards the cores.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q <= '0;
    end else begin
      irq_q <= irq_cmp;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = irq_cmp;
`endif

endmodule

// File: tb/tb_rtc_timer_bank.sv
// ---------------------------------------------------------------------------
// tb_rtc_timer_bank
//
// Purpose:
//   Directed self-checking bench for rtc_timer_bank with four harts. Read
//   expectations go into a scoreboard queue when a read is issued and are
//   popped when the response arrives.
// ---------------------------------------------------------------------------
module tb_rtc_timer_bank;

  localparam int unsigned NR_CORES = 4;
  localparam logic [63:0] ONES     = 64'hFFFF_FFFF_FFFF_FFFF;

  logic                clk;
  logic                rst_n;
  logic                rtc;
  logic [63:0]         time_val;
  logic [NR_CORES-1:0] irq;

  int compared   = 0;
  int mismatched = 0;
  logic [63:0] expQ [$];

  rtc_timer_bank_if #(.ADDR_WIDTH(16)) bus ();

  rtc_timer_bank #(
    .NR_CORES       (NR_CORES),
    .ADDR_WIDTH     (16),
    .STABLE_CYCLES  (5),
    .PRESCALE_WIDTH (8)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus),
    .rtc_i  (rtc),
    .time_o (time_val),
    .irq_o  (irq)
  );

  // Free-running 100 MHz system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something never returns.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One bus request; entered and left just after a rising edge.
  task automatic applyStimulus(input logic we, input logic [15:0] addr,
                               input logic [7:0] be, input logic [63:0] wdata);
    bus.req_i   = 1'b1;
    bus.we_i    = we;
    bus.addr_i  = addr;
    bus.be_i    = be;
    bus.wdata_i = wdata;
    #1;
    checkOutput("gnt", {63'b0, bus.gnt_o}, 64'd1);
    @(posedge clk);
    #1;
    bus.req_i   = 1'b0;
    bus.we_i    = 1'b0;
    bus.be_i    = '0;
    bus.wdata_i = '0;
  endtask

  task automatic busRead(input string tag, input logic [15:0] addr, input logic [63:0] exp);
    logic [63:0] e;
    expQ.push_back(exp);
    applyStimulus(1'b0, addr, 8'h00, 64'd0);
    checkOutput({tag, "_rvalid"}, {63'b0, bus.rvalid_o}, 64'd1);
    if (bus.rvalid_o && expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(tag, bus.rdata_o, e);
    end
  endtask

  task automatic busWrite(input string tag, input logic [15:0] addr,
                          input logic [7:0] be, input logic [63:0] data);
    applyStimulus(1'b1, addr, be, data);
    checkOutput({tag, "_rvalid"}, {63'b0, bus.rvalid_o}, 64'd1);
  endtask

  task automatic rtcPulse(input int high, input int low);
    rtc = 1'b1;
    repeat (high) begin @(posedge clk); #1; end
    rtc = 1'b0;
    repeat (low) begin @(posedge clk); #1; end
  endtask

  // Allows for the extra interrupt register in that build.
  task automatic irqSettle();
`ifdef RTC_TIMER_IRQ_REG_EN
    @(posedge clk);
    #1;
`endif
  endtask

  initial begin
    logic       found;
    int         lat;
    logic [63:0] t0;

    rtc         = 1'b0;
    bus.req_i   = 1'b0;
    bus.we_i    = 1'b0;
    bus.addr_i  = '0;
    bus.be_i    = '0;
    bus.wdata_i = '0;
    rst_n       = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] reset values");
    checkOutput("reset_rvalid", {63'b0, bus.rvalid_o}, 64'd0);
    checkOutput("reset_rdata", bus.rdata_o, 64'd0);
    checkOutput("reset_time", time_val, 64'd0);
    checkOutput("reset_irq", {60'b0, irq}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_reset_rvalid", {63'b0, bus.rvalid_o}, 64'd0);
    busRead("cmp0_reset", 16'h1000, ONES);
    checkOutput("irq_after_reset", {60'b0, irq}, 64'd0);
    checkOutput("time_after_reset", time_val, 64'd0);
    busRead("ctrl_reset", 16'h0000, 64'd0);

    $display("[TB] EN, DIV=0, ten RTC periods");
    busWrite("ctrl_div0", 16'h0000, 8'hFF, 64'h1);
    repeat (10) rtcPulse(20, 20);
    busRead("mtime_div0", 16'h0008, 64'd10);
    checkOutput("time_div0", time_val, 64'd10);

    $display("[TB] DIV=3, eight RTC periods");
    busWrite("mtime_clear", 16'h0008, 8'hFF, 64'd0);
    busWrite("ctrl_div3", 16'h0000, 8'hFF, 64'h0301);
    busRead("ctrl_div3_rd", 16'h0000, 64'h0301);
    repeat (8) rtcPulse(20, 20);
    busRead("mtime_div3", 16'h0008, 64'd2);

    $display("[TB] short glitches");
    busWrite("ctrl_div0_b", 16'h0000, 8'hFF, 64'h1);
    repeat (4) rtcPulse(3, 10);
    busRead("mtime_glitch", 16'h0008, 64'd2);

    $display("[TB] hart 2 compare");
    busWrite("mtime_zero", 16'h0008, 8'hFF, 64'd0);
    busWrite("cmp2_five", 16'h1010, 8'hFF, 64'd5);
    repeat (4) rtcPulse(20, 20);
    checkOutput("time_four", time_val, 64'd4);
    checkOutput("irq_below", {60'b0, irq}, 64'd0);
    rtc   = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge clk);
      #1;
      if (time_val == 64'd5) found = 1'b1;
    end
    checkOutput("time_reach_five", {63'b0, found}, 64'd1);
    irqSettle();
    checkOutput("irq_at_five", {60'b0, irq}, 64'h4);
    repeat (20) begin @(posedge clk); #1; end
    rtc = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    busWrite("cmp2_hundred", 16'h1010, 8'hFF, 64'd100);
    irqSettle();
    checkOutput("irq_cleared", {60'b0, irq}, 64'd0);
    busRead("cmp2_rd", 16'h1010, 64'd100);
    busRead("cmp3_rd", 16'h1018, ONES);
    busWrite("cmp4_oob", 16'h1020, 8'hFF, 64'h55);
    busRead("cmp4_oob_rd", 16'h1020, 64'd0);
    busWrite("unmapped_wr", 16'h0010, 8'hFF, 64'h77);
    busRead("unmapped_rd", 16'h0010, 64'd0);

    $display("[TB] wrap and byte enables");
    busWrite("mtime_ones", 16'h0008, 8'hFF, ONES);
    busRead("mtime_ones_rd", 16'h0008, ONES);
    irqSettle();
    checkOutput("irq_all", {60'b0, irq}, 64'hF);
    rtcPulse(20, 20);
    busRead("mtime_wrapped", 16'h0008, 64'd0);
    checkOutput("irq_after_wrap", {60'b0, irq}, 64'd0);
    busWrite("mtime_lo_be", 16'h0008, 8'h0F, 64'h1234);
    busRead("mtime_lo_be_rd", 16'h0008, 64'h1234);
    busWrite("mtime_pattern", 16'h0008, 8'hFF, 64'hDEAD_BEEF_0000_0000);
    busWrite("mtime_lo_be2", 16'h0008, 8'h0F, 64'hFFFF_FFFF_0000_5678);
    busRead("mtime_upper_kept", 16'h0008, 64'hDEAD_BEEF_0000_5678);

    $display("[TB] write against tick");
    busWrite("mtime_base", 16'h0008, 8'hFF, 64'h100);
    t0  = time_val;
    lat = 0;
    rtc = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (lat == 0 && time_val != t0) lat = c;
    end
    rtc = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    checkOutput("tick_seen", {63'b0, (lat != 0)}, 64'd1);
    checkOutput("time_base_inc", time_val, 64'h101);
    if (lat != 0) begin
      rtc = 1'b1;
      for (int c = 1; c < lat; c++) begin @(posedge clk); #1; end
      busWrite("mtime_vs_tick", 16'h0008, 8'hFF, 64'h5555);
      repeat (20 - lat) begin @(posedge clk); #1; end
      rtc = 1'b0;
      repeat (20) begin @(posedge clk); #1; end
      busRead("mtime_write_wins", 16'h0008, 64'h5555);
    end

    $display("[TB] reset with response in flight");
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = 16'h0008;
    @(posedge clk);
    #1;
    bus.req_i  = 1'b0;
    checkOutput("inflight_rvalid", {63'b0, bus.rvalid_o}, 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_rvalid", {63'b0, bus.rvalid_o}, 64'd0);
    checkOutput("midreset_time", time_val, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("after_midreset_rvalid", {63'b0, bus.rvalid_o}, 64'd0);
    busRead("cmp2_after_reset", 16'h1010, ONES);
    busRead("ctrl_after_reset", 16'h0000, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rtc_timer_bank.md
Name: rtc_timer_bank

Overview:
- Parametrised multi-hart machine timer: one shared 64-bit mtime and NR_CORES independent mtimecmp registers.
- Produces a per-hart level timer interrupt vector.
- mtime advances on debounced rising edges of an asynchronous RTC input, divided by a programmable prescaler.
- Sits behind the SoC peripheral register bus (simple req/we/be handshake) and drives the global time base and the core MTIP lines.

Parameters:
- NR_CORES, 1, number of harts: mtimecmp registers and irq_o bits (1..64).
- ADDR_WIDTH, 16, byte-address width of the register port.
- STABLE_CYCLES, 5, consecutive high samples of synchronised RTC required before one tick (>=1).
- PRESCALE_WIDTH, 8, width of the prescaler divisor field.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  register access request.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  ADDR_WIDTH  byte address; bits [2:0] ignored.
- be_i  in  8  byte enables for writes.
- wdata_i  in  64  write data.
- gnt_o  in-phase  out  1  grant; equals req_i (never stalls).
- rvalid_o  out  1  response valid, one cycle after an accepted request (reads and writes).
- rdata_o  out  64  read data, valid with rvalid_o, else 0.
- rtc_i  in  1  asynchronous real-time clock (~32.768 kHz).
- time_o  out  64  mtime_q.
- irq_o  out  NR_CORES  per-hart timer interrupt.

Behaviour:
Clocking and reset:
- Single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: mtime=0, every mtimecmp=all-ones, CTRL=0 (disabled, divisor 0), FSM=WAIT_HIGH, counters=0.
- Output reset values: rvalid_o=0, rdata_o=0, irq_o=0, time_o=0.

Register map (byte offset):
- 0x0000 CTRL: bit0 EN; bits [8+PRESCALE_WIDTH-1:8] DIV; other bits read 0.
- 0x0008 MTIME.
- 0x1000+8*i MTIMECMP[i].
- Unmapped or out-of-range i: writes ignored, reads return 0, rvalid_o still pulses.

Register access:
- Writes are byte-masked by be_i and take effect at the next clock edge.
- Read data reflects register state before any same-cycle write or increment.

RTC path:
- rtc_i passes through a two-flop synchroniser (rtc_s).
- FSM transitions:
  - WAIT_HIGH: rtc_s=1 -> COUNT, cnt=0.
  - COUNT: rtc_s=0 -> WAIT_HIGH; else cnt++; cnt==STABLE_CYCLES-1 while high -> TICK.
  - TICK: one-cycle tick pulse -> WAIT_LOW.
  - WAIT_LOW: rtc_s=0 -> WAIT_HIGH.
- Result: exactly one tick per RTC high phase that lasts >=STABLE_CYCLES samples; glitches shorter than that produce none.
- The FSM runs regardless of EN.

Prescaler:
- On tick with EN=1: if pcnt==DIV, then pcnt=0 and mtime+=1; else pcnt++.
- DIV=0 gives one increment per tick.
- Writing CTRL clears pcnt.
- EN=0 freezes mtime and pcnt.

Arithmetic and priority:
- mtime wraps 2^64-1 -> 0 with no flag.
- A bus write to MTIME in the same cycle as an increment wins; the increment is lost.

Interrupts:
- irq_o[i] = (mtime_q >= mtimecmp_q[i]), unsigned, combinational from registers.
- Cleared only by writing mtimecmp or mtime.

Reset mid-operation:
- Any in-flight response is dropped; rvalid_o=0 on the first cycle after reset release.

Optional Feature:
- RTC_TIMER_IRQ_REG_EN defined: irq_o is registered, i.e. one extra cycle of latency after the compare condition changes; reset value 0.
- Not defined: combinational compare as above.
- Register read/write behaviour is identical in both builds.

Test Plan:
- Reset, then read 0x1000 -> rvalid_o one cycle later, rdata 0xFFFF_FFFF_FFFF_FFFF; irq_o=0; time_o=0.
- CTRL=0x1 (EN, DIV=0), 10 clean RTC periods each high 20 clk -> MTIME reads 10.
- CTRL=0x0301 (DIV=3), 8 RTC periods -> MTIME=2.
- RTC high glitches of 3 clk with STABLE_CYCLES=5 -> MTIME unchanged.
- NR_CORES=4: MTIMECMP[2]=5, mtime runs to 5 -> irq_o=4'b0100 in the cycle mtime_q=5.
  - Then write MTIMECMP[2]=100 -> irq_o=0 next cycle.
- MTIME=0xFFFF_FFFF_FFFF_FFFF, then one tick -> 0.
  - Write be=0x0F data 0x1234 to MTIME=0 -> MTIME=0x1234, upper 32 bits untouched.
  - Write to MTIME coinciding with a tick -> written value kept.
